// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (IF fetch, MEM load/store) for the core's single memory port.
// Grants are locked until the address handshake; responses are steered via an in-order owner queue.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                inst_cancel,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  // state | meaning
  // IDLE  | no grant, bus_req low
  // GNT_D | MEM owns the request channel until bus_addr_ok
  // GNT_I | IF owns the request channel until bus_addr_ok
  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  state_t                     state;
  logic [PTR_W-1:0]           head, tail;
  logic [CNT_W-1:0]           count, count_next;
  logic [MAX_OUTSTANDING-1:0] own_i, discard;
  logic                       cancel_pend;

  logic gnt_d, gnt_i, push, pop, full_next;
  logic data_req_eff, inst_req_eff, head_is_i, head_disc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign gnt_d = (state == GNT_D);
  assign gnt_i = (state == GNT_I);

  assign bus_req   = gnt_d | gnt_i;
  assign bus_wr    = gnt_d & data_wr;
  assign bus_size  = gnt_d ? data_size : (gnt_i ? 2'd2 : 2'd0);
  assign bus_wstrb = gnt_d ? data_wstrb : '0;
  assign bus_addr  = gnt_d ? data_addr : (gnt_i ? inst_addr : '0);
  assign bus_wdata = gnt_d ? data_wdata : '0;

  assign data_addr_ok = gnt_d & bus_addr_ok;
  assign inst_addr_ok = gnt_i & bus_addr_ok;
  assign push         = data_addr_ok | inst_addr_ok;

  assign head_is_i    = own_i[head];
  assign head_disc    = discard[head];
  assign pop          = bus_data_ok & (count != '0);
  assign data_data_ok = pop & ~head_is_i;
  assign inst_data_ok = pop & head_is_i & ~head_disc;
  assign data_rdata   = data_data_ok ? bus_rdata : '0;
  assign inst_rdata   = inst_data_ok ? bus_rdata : '0;

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign full_next  = (count_next == CNT_W'(MAX_OUTSTANDING));

  // A request accepted this cycle is consumed; it must not win the next grant again.
  assign data_req_eff = data_req & ~data_addr_ok;
  assign inst_req_eff = inst_req & ~inst_addr_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      own_i       <= '0;
      discard     <= '0;
      cancel_pend <= 1'b0;
    end else begin
      if (pop) head <= ptr_inc(head);
      if (inst_cancel) discard <= discard | own_i;
      if (push) begin
        own_i[tail]   <= gnt_i;
        discard[tail] <= gnt_i & (inst_cancel | cancel_pend);
        tail          <= ptr_inc(tail);
      end
      count <= count_next;

      // Cancel seen while the IF request is still waiting for acceptance.
      if (push) cancel_pend <= 1'b0;
      else if (gnt_i && inst_cancel) cancel_pend <= 1'b1;

      if (state == IDLE || push) begin
        if (!full_next && data_req_eff) state <= GNT_D;
        else if (!full_next && inst_req_eff) state <= GNT_I;
        else state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the main flow plus
// hand-written multi-cycle sequences for stall, full queue, cancel and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq, dwr;
    logic [3:0]  dwstrb;
    logic [31:0] daddr, dwdata;
    logic        baok, bdok;
    logic [31:0] brdata;
    logic        e_breq;
    logic [31:0] e_baddr;
    logic        e_bwr;
    logic [3:0]  e_bwstrb;
    logic [31:0] e_bwdata;
    logic        e_iaok, e_daok, e_idok, e_ddok;
    logic [31:0] e_drdata, e_irdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, ".bus_req"}, 32'(bus_req), 0);
    chk({tag, ".bus_addr"}, bus_addr, 0);
    chk({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 0);
    chk({tag, ".data_addr_ok"}, 32'(data_addr_ok), 0);
    chk({tag, ".inst_data_ok"}, 32'(inst_data_ok), 0);
    chk({tag, ".data_data_ok"}, 32'(data_data_ok), 0);
  endtask

  initial begin
    //          ireq iaddr         dreq dwr wstrb daddr   dwdata        baok bdok brdata
    //          | breq baddr        bwr bwstrb bwdata     iaok daok idok ddok drdata       irdata
    vecs[0] = '{1, 32'h1c000000, 1, 0, 4'h0, 32'h100, 32'h0,        1, 0, 32'h0,
                0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0};
    vecs[1] = '{1, 32'h1c000000, 1, 0, 4'h0, 32'h100, 32'h0,        1, 0, 32'h0,
                1, 32'h100,      0, 4'h0, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0};
    vecs[2] = '{1, 32'h1c000000, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0,
                1, 32'h1c000000, 0, 4'h0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0};
    vecs[3] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h11111111,
                0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 0, 1, 32'h11111111, 32'h0};
    vecs[4] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h22222222,
                0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h22222222};
    vecs[5] = '{0, 32'h0,        1, 1, 4'h3, 32'h8,   32'h12345678, 0, 0, 32'h0,
                0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0};
    vecs[6] = '{0, 32'h0,        1, 1, 4'h3, 32'h8,   32'h12345678, 0, 0, 32'h0,
                1, 32'h8,        1, 4'h3, 32'h12345678, 0, 0, 0, 0, 32'h0,        32'h0};
    vecs[7] = '{0, 32'h0,        1, 1, 4'h3, 32'h8,   32'h12345678, 1, 0, 32'h0,
                1, 32'h8,        1, 4'h3, 32'h12345678, 0, 1, 0, 0, 32'h0,        32'h0};
    vecs[8] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h0badf00d,
                0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 0, 1, 32'h0badf00d, 32'h0};
    vecs[9] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hdeadbeef,
                0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0};

    idle_inputs();
    resetn = 0;
    step();
    smp();
    chk_all_quiet("reset");
    step();
    resetn = 1;

    // Main flow: priority, back-to-back grants, routing, store, empty-queue response.
    for (int i = 0; i < 10; i++) begin
      inst_req = vecs[i].ireq; inst_addr = vecs[i].iaddr;
      data_req = vecs[i].dreq; data_wr = vecs[i].dwr; data_wstrb = vecs[i].dwstrb;
      data_addr = vecs[i].daddr; data_wdata = vecs[i].dwdata;
      bus_addr_ok = vecs[i].baok; bus_data_ok = vecs[i].bdok; bus_rdata = vecs[i].brdata;
      smp();
      chk($sformatf("v%0d.bus_req", i), 32'(bus_req), 32'(vecs[i].e_breq));
      chk($sformatf("v%0d.bus_addr", i), bus_addr, vecs[i].e_baddr);
      chk($sformatf("v%0d.bus_wr", i), 32'(bus_wr), 32'(vecs[i].e_bwr));
      chk($sformatf("v%0d.bus_wstrb", i), 32'(bus_wstrb), 32'(vecs[i].e_bwstrb));
      chk($sformatf("v%0d.bus_wdata", i), bus_wdata, vecs[i].e_bwdata);
      chk($sformatf("v%0d.inst_addr_ok", i), 32'(inst_addr_ok), 32'(vecs[i].e_iaok));
      chk($sformatf("v%0d.data_addr_ok", i), 32'(data_addr_ok), 32'(vecs[i].e_daok));
      chk($sformatf("v%0d.inst_data_ok", i), 32'(inst_data_ok), 32'(vecs[i].e_idok));
      chk($sformatf("v%0d.data_data_ok", i), 32'(data_data_ok), 32'(vecs[i].e_ddok));
      chk($sformatf("v%0d.data_rdata", i), data_rdata, vecs[i].e_drdata);
      chk($sformatf("v%0d.inst_rdata", i), inst_rdata, vecs[i].e_irdata);
      step();
    end
    idle_inputs();
    step();

    // Stalled IF grant is not preempted by a late data request.
    inst_req = 1; inst_addr = 32'h1c000040;
    step();
    smp(); chk("stall.c0.bus_addr", bus_addr, 32'h1c000040);
    step(); data_req = 1; data_addr = 32'h200;
    smp(); chk("stall.c1.bus_addr", bus_addr, 32'h1c000040);
    chk("stall.c1.data_addr_ok", 32'(data_addr_ok), 0);
    step();
    smp(); chk("stall.c2.inst_addr_ok", 32'(inst_addr_ok), 0);
    step(); bus_addr_ok = 1;
    smp(); chk("stall.c3.inst_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 0;
    smp(); chk("stall.c4.data_addr_ok", 32'(data_addr_ok), 1);
    chk("stall.c4.bus_addr", bus_addr, 32'h200);
    step(); data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h01;
    smp(); chk("stall.r0.inst_data_ok", 32'(inst_data_ok), 1);
    step(); bus_rdata = 32'h02;
    smp(); chk("stall.r1.data_data_ok", 32'(data_data_ok), 1);
    chk("stall.r1.data_rdata", data_rdata, 32'h02);
    step(); bus_data_ok = 0;

    // Full queue blocks the next grant until a response frees a slot.
    data_req = 1; data_addr = 32'h300; inst_req = 1; inst_addr = 32'h1c000080; bus_addr_ok = 1;
    step();
    smp(); chk("full.d0.data_addr_ok", 32'(data_addr_ok), 1);
    step(); data_addr = 32'h304;
    smp(); chk("full.i0.inst_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 0;
    smp(); chk("full.blk0.bus_req", 32'(bus_req), 0);
    step();
    smp(); chk("full.blk1.bus_req", 32'(bus_req), 0);
    chk("full.blk1.data_addr_ok", 32'(data_addr_ok), 0);
    step(); bus_data_ok = 1; bus_rdata = 32'h33;
    smp(); chk("full.pop.data_data_ok", 32'(data_data_ok), 1);
    chk("full.pop.data_rdata", data_rdata, 32'h33);
    step(); bus_data_ok = 0;
    smp(); chk("full.regnt.bus_req", 32'(bus_req), 1);
    chk("full.regnt.bus_addr", bus_addr, 32'h304);
    chk("full.regnt.data_addr_ok", 32'(data_addr_ok), 1);
    step(); data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h44;
    smp(); chk("full.drain0.inst_data_ok", 32'(inst_data_ok), 1);
    chk("full.drain0.inst_rdata", inst_rdata, 32'h44);
    step(); bus_rdata = 32'h55;
    smp(); chk("full.drain1.data_data_ok", 32'(data_data_ok), 1);
    step(); idle_inputs();

    // Cancel drops a queued fetch but leaves the load intact.
    inst_req = 1; inst_addr = 32'h1c000000; bus_addr_ok = 1;
    step(); data_req = 1; data_addr = 32'h100;
    smp(); chk("cancel.i.inst_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 0;
    smp(); chk("cancel.d.data_addr_ok", 32'(data_addr_ok), 1);
    step(); data_req = 0; bus_addr_ok = 0; inst_cancel = 1;
    step(); inst_cancel = 0; bus_data_ok = 1; bus_rdata = 32'h0000aaaa;
    smp(); chk("cancel.r0.inst_data_ok", 32'(inst_data_ok), 0);
    chk("cancel.r0.data_data_ok", 32'(data_data_ok), 0);
    step(); bus_rdata = 32'h00005555;
    smp(); chk("cancel.r1.data_data_ok", 32'(data_data_ok), 1);
    chk("cancel.r1.data_rdata", data_rdata, 32'h00005555);
    chk("cancel.r1.inst_data_ok", 32'(inst_data_ok), 0);
    step(); bus_data_ok = 0;

    // Cancel while the fetch is still waiting for acceptance.
    inst_req = 1; inst_addr = 32'h1c000100;
    step(); inst_cancel = 1;
    smp(); chk("pend.bus_req", 32'(bus_req), 1);
    step(); inst_cancel = 0; bus_addr_ok = 1;
    smp(); chk("pend.inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("pend.bus_addr", bus_addr, 32'h1c000100);
    step(); inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h77;
    smp(); chk("pend.inst_data_ok", 32'(inst_data_ok), 0);
    step(); bus_data_ok = 0;

    // Synchronous reset with two entries in flight.
    data_req = 1; data_addr = 32'h400; inst_req = 1; inst_addr = 32'h1c000200; bus_addr_ok = 1;
    step(); 
    smp(); chk("rst.d.data_addr_ok", 32'(data_addr_ok), 1);
    step(); data_req = 0;
    smp(); chk("rst.i.inst_addr_ok", 32'(inst_addr_ok), 1);
    step(); inst_req = 0; bus_addr_ok = 0; resetn = 0;
    step(); resetn = 1;
    smp(); chk_all_quiet("rst.after");
    step(); bus_data_ok = 1; bus_rdata = 32'h99;
    smp(); chk("rst.resp.data_data_ok", 32'(data_data_ok), 0);
    chk("rst.resp.inst_data_ok", 32'(inst_data_ok), 0);
    step(); bus_data_ok = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
